// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier: two multiplier bits per clock, signed or unsigned per operation.
// Optional BOOTH_MUL_EARLY_TERM_EN finishes as soon as every remaining Booth digit is zero.
module booth_mul_r4 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 valid,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int QW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   m_reg, m_next;
    logic [QW-1:0]   q_reg, q_next;
    logic [PW-1:0]   p_reg, p_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [PW-1:0]   z_reg, z_next;
    logic            valid_reg, valid_next;

    logic [PW-1:0]   addend;
    logic [PW-1:0]   p_sum;
    logic [QW-1:0]   q_shift;
    logic            x_ext, y_ext;
    logic            last, done;

    assign x_ext   = is_signed & X[WIDTH-1];
    assign y_ext   = is_signed & Y[WIDTH-1];
    assign q_shift = {{2{q_reg[QW-1]}}, q_reg[QW-1:2]};
    assign p_sum   = p_reg + addend;
    assign last    = (cnt_reg == LAST_DIGIT);

`ifdef BOOTH_MUL_EARLY_TERM_EN
    // Remaining bits all equal means every later digit recodes to zero.
    assign done = last | (&q_shift) | ~(|q_shift);
`else
    assign done = last;
`endif

    always_comb begin
        addend = '0;
        case (q_reg[2:0])
            3'b001, 3'b010: addend = m_reg;
            3'b011:         addend = m_reg << 1;
            3'b100:         addend = -(m_reg << 1);
            3'b101, 3'b110: addend = -m_reg;
            default:        addend = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        q_next     = q_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;
        z_next     = z_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    m_next     = {{WIDTH{x_ext}}, X};
                    q_next     = {{2{y_ext}}, Y, 1'b0};
                    p_next     = '0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                p_next   = p_sum;
                m_next   = m_reg << 2;
                q_next   = q_shift;
                cnt_next = cnt_reg + 1'b1;
                if (done) begin
                    state_next = IDLE;
                    z_next     = p_sum;
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            m_reg     <= '0;
            q_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            z_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            m_reg     <= m_next;
            q_reg     <= q_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
            z_reg     <= z_next;
            valid_reg <= valid_next;
        end
    end

    assign Z     = z_reg;
    assign valid = valid_reg;
    assign busy  = (state_reg == RUN);

endmodule
